hack_data_mem: RTL and testbench

HACK_DATA_MEM -- requirements
Module: hack_data_mem

---
 rtl/hack_data_mem.sv | 105 ++++++++++
 tb/tb_hack_data_mem.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hack_data_mem.sv
// Hack data memory: 16K RAM, 8K screen shadow with a 4-entry display FIFO,
// a keyboard register and a sticky unmapped-address flag.
module hack_data_mem (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] addressM,
   input  logic [15:0] outM,
   input  logic        writeM,
   output logic [15:0] inM,
   output logic        stall,
   input  logic [15:0] kbd_code,
   input  logic        kbd_valid,
   output logic        disp_valid,
   input  logic        disp_ready,
   output logic [12:0] disp_addr,
   output logic [15:0] disp_data,
   output logic [2:0]  fifo_level,
   output logic        bad_addr
);

   logic [15:0] ram    [0:16383];
   logic [15:0] screen [0:8191];
   logic [28:0] fifoMem [0:3];

   logic [1:0]  wrPtr;
   logic [1:0]  rdPtr;
   logic [2:0]  level;
   logic [15:0] kbdReg;
   logic        badAddr;

   logic isRam;
   logic isScreen;
   logic isKbd;
   logic isUnmapped;
   logic full;
   logic push;
   logic pop;

   assign isRam      = (addressM[15:14] == 2'b00);
   assign isScreen   = (addressM[15:13] == 3'b010);
   assign isKbd      = (addressM == 16'h6000);
   assign isUnmapped = (addressM > 16'h6000);

   // Stall looks only at the registered level, so a same-cycle pop never frees a slot.
   assign full  = (level == 3'd4);
   assign stall = writeM & isScreen & full;
   assign push  = writeM & isScreen & ~full;
   assign pop   = (level != 3'd0) & disp_ready;

   always_ff @(posedge clk) begin
      if (writeM && isRam) begin
         ram[addressM[13:0]] <= outM;
      end
      if (push) begin
         screen[addressM[12:0]] <= outM;
         fifoMem[wrPtr]         <= {addressM[12:0], outM};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr   <= 2'd0;
         rdPtr   <= 2'd0;
         level   <= 3'd0;
         kbdReg  <= 16'h0000;
         badAddr <= 1'b0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 2'd1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 2'd1;
         end
         if (push && !pop) begin
            level <= level + 3'd1;
         end else if (pop && !push) begin
            level <= level - 3'd1;
         end
         if (kbd_valid) begin
            kbdReg <= kbd_code;
         end
         if (isUnmapped) begin
            badAddr <= 1'b1;
         end
      end
   end

   always_comb begin
      inM = 16'h0000;
      if (isRam) begin
         inM = ram[addressM[13:0]];
      end else if (isScreen) begin
         inM = screen[addressM[12:0]];
      end else if (isKbd) begin
         inM = kbdReg;
      end
   end

   assign disp_valid = (level != 3'd0);
   assign disp_addr  = fifoMem[rdPtr][28:16];
   assign disp_data  = fifoMem[rdPtr][15:0];
   assign fifo_level = level;
   assign bad_addr   = badAddr;

endmodule

// File: tb/tb_hack_data_mem.sv
// Directed bench for hack_data_mem: queue/array reference model compared every
// cycle, plus literal expectations at the key points of each scenario.
module tb_hack_data_mem;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] addressM = 16'h0000;
   logic [15:0] outM = 16'h0000;
   logic        writeM = 1'b0;
   logic [15:0] inM;
   logic        stall;
   logic [15:0] kbd_code = 16'h0000;
   logic        kbd_valid = 1'b0;
   logic        disp_valid;
   logic        disp_ready = 1'b0;
   logic [12:0] disp_addr;
   logic [15:0] disp_data;
   logic [2:0]  fifo_level;
   logic        bad_addr;

   int checks = 0;
   int errors = 0;

   hack_data_mem dut (
      .clk(clk), .reset_n(reset_n), .addressM(addressM), .outM(outM),
      .writeM(writeM), .inM(inM), .stall(stall), .kbd_code(kbd_code),
      .kbd_valid(kbd_valid), .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_addr(disp_addr), .disp_data(disp_data), .fifo_level(fifo_level),
      .bad_addr(bad_addr)
   );

   always #5 clk = ~clk;

   // Reference model
   logic [15:0] mRam [0:16383];
   bit          mRamK [0:16383];
   logic [15:0] mScr [0:8191];
   bit          mScrK [0:8191];
   logic [28:0] q [$];
   logic [15:0] mKbd = 16'h0000;
   bit          mBad = 1'b0;
   bit          doPush;
   bit          doPop;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         mKbd = 16'h0000;
         mBad = 1'b0;
      end else begin
         doPop  = (q.size() > 0) && disp_ready;
         doPush = 1'b0;
         if (writeM) begin
            if (addressM < 16'h4000) begin
               mRam[addressM[13:0]]  = outM;
               mRamK[addressM[13:0]] = 1'b1;
            end else if (addressM < 16'h6000 && q.size() < 4) begin
               mScr[addressM[12:0]]  = outM;
               mScrK[addressM[12:0]] = 1'b1;
               doPush = 1'b1;
            end
         end
         if (doPop) void'(q.pop_front());
         if (doPush) q.push_back({addressM[12:0], outM});
         if (kbd_valid) mKbd = kbd_code;
         if (addressM > 16'h6000) mBad = 1'b1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      logic [15:0] e;
      bit          known;
      check("cmp_level", {13'd0, fifo_level}, q.size());
      check("cmp_valid", {15'd0, disp_valid}, {15'd0, q.size() > 0});
      check("cmp_bad", {15'd0, bad_addr}, {15'd0, mBad});
      check("cmp_stall", {15'd0, stall},
            {15'd0, writeM && addressM >= 16'h4000 && addressM < 16'h6000 && q.size() == 4});
      if (q.size() > 0) begin
         check("cmp_daddr", {3'd0, disp_addr}, {3'd0, q[0][28:16]});
         check("cmp_ddata", disp_data, q[0][15:0]);
      end
      known = 1'b1;
      e = 16'h0000;
      if (addressM < 16'h4000) begin
         known = mRamK[addressM[13:0]];
         e = mRam[addressM[13:0]];
      end else if (addressM < 16'h6000) begin
         known = mScrK[addressM[12:0]];
         e = mScr[addressM[12:0]];
      end else if (addressM == 16'h6000) begin
         e = mKbd;
      end
      if (known) check("cmp_inM", inM, e);
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      addressM = a;
      outM     = d;
      writeM   = 1'b1;
      cycle();
      writeM   = 1'b0;
   endtask

   task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
      addressM = a;
      #1;
      check(name, inM, exp);
   endtask

   initial begin
      #2;
      check("rst_valid", {15'd0, disp_valid}, 16'h0000);
      check("rst_level", {13'd0, fifo_level}, 16'h0000);
      check("rst_bad", {15'd0, bad_addr}, 16'h0000);
      cycle();
      cycle();
      reset_n = 1'b1;

      // RAM
      wr(16'h0005, 16'h1234);
      rd("ram_5", 16'h0005, 16'h1234);
      addressM = 16'h3FFF; outM = 16'hBEEF; writeM = 1'b1;
      #1;
      check("ram_stall", {15'd0, stall}, 16'h0000);
      cycle();
      writeM = 1'b0;
      rd("ram_3fff", 16'h3FFF, 16'hBEEF);

      // Preload shadow at 0x4004 and drain it
      disp_ready = 1'b1;
      wr(16'h4004, 16'hAAAA);
      cycle();
      cycle();
      check("drain_level", {13'd0, fifo_level}, 16'h0000);
      disp_ready = 1'b0;

      // FIFO fill
      for (int i = 0; i < 4; i++) wr(16'h4000 + 16'(i), 16'(i + 1));
      check("fill_level", {13'd0, fifo_level}, 16'h0004);
      addressM = 16'h4004; outM = 16'h0005; writeM = 1'b1;
      #1;
      check("fill_stall", {15'd0, stall}, 16'h0001);
      cycle();
      writeM = 1'b0;
      rd("fill_shadow", 16'h4004, 16'hAAAA);
      check("fill_level2", {13'd0, fifo_level}, 16'h0004);
      addressM = 16'h0000;
      disp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("pop_addr", {3'd0, disp_addr}, 16'(i));
         check("pop_data", disp_data, 16'(i + 1));
         cycle();
      end
      check("pop_empty", {15'd0, disp_valid}, 16'h0000);
      disp_ready = 1'b0;

      // Push with pop
      wr(16'h4010, 16'h0010);
      wr(16'h4011, 16'h0011);
      disp_ready = 1'b1;
      wr(16'h4012, 16'h0012);
      disp_ready = 1'b0;
      check("pp_level", {13'd0, fifo_level}, 16'h0002);
      check("pp_head", disp_data, 16'h0011);
      wr(16'h4013, 16'h0013);
      wr(16'h4014, 16'h0014);
      disp_ready = 1'b1;
      addressM = 16'h4015; outM = 16'h0015; writeM = 1'b1;
      #1;
      check("pp_stall", {15'd0, stall}, 16'h0001);
      cycle();
      writeM = 1'b0;
      disp_ready = 1'b0;
      check("pp_level3", {13'd0, fifo_level}, 16'h0003);
      check("pp_head2", disp_data, 16'h0012);

      // Keyboard
      kbd_code = 16'h0041; kbd_valid = 1'b1;
      cycle();
      kbd_valid = 1'b0; kbd_code = 16'h0000;
      rd("kbd_read", 16'h6000, 16'h0041);
      wr(16'h6000, 16'hFFFF);
      rd("kbd_hold", 16'h6000, 16'h0041);

      // Unmapped
      wr(16'h3000, 16'h5555);
      addressM = 16'h7000; outM = 16'h9999; writeM = 1'b1;
      #1;
      check("bad_before", {15'd0, bad_addr}, 16'h0000);
      cycle();
      writeM = 1'b0;
      check("bad_set", {15'd0, bad_addr}, 16'h0001);
      rd("unmap_read", 16'h7000, 16'h0000);
      rd("mirror_3000", 16'h3000, 16'h5555);
      cycle();
      check("bad_sticky", {15'd0, bad_addr}, 16'h0001);

      // Reset mid-operation at level 3
      check("mid_level", {13'd0, fifo_level}, 16'h0003);
      addressM = 16'h6000;
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_valid", {15'd0, disp_valid}, 16'h0000);
      check("ar_level", {13'd0, fifo_level}, 16'h0000);
      check("ar_kbd", inM, 16'h0000);
      check("ar_bad", {15'd0, bad_addr}, 16'h0000);
      cycle();
      reset_n = 1'b1;
      wr(16'h0100, 16'h0077);
      rd("post_rst_ram", 16'h0100, 16'h0077);
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
